// File: rtl/load_ext_unit.sv
// load_ext_unit: takes memory read words, extracts a byte/half/word/full
// field at a byte offset, sign- or zero-extends it to XLEN and presents it
// through a one-entry result register. A field that runs past the end of the
// word is either stitched together from two consecutive beats or reported as
// an error, depending on MISALIGN_EN.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; a
// result retires on a rising edge where out_valid && out_ready. in_ready is
// purely combinational (!out_valid || out_ready), so a retiring result frees
// the register for a new beat in the same cycle. The result register holds
// out_data/out_err stable while out_valid && !out_ready.
module load_ext_unit #(
  parameter int XLEN        = 32,
  parameter int MISALIGN_EN = 1,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_mode,
  input  logic [OW-1:0]   in_offset,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err,
  output logic            split_pending
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HOLD_LO = 1'b1
  } state_t;

  localparam logic [OW:0] NB_W = (OW+1)'(NB);

  state_t          state_q, state_d;
  logic [2:0]      mode_q;
  logic [OW-1:0]   off_q;
  logic [XLEN-1:0] lo_q;

  logic            accept;
  logic            load;
  logic            capture;
  logic [2:0]      eff_mode;
  logic [OW:0]     size_b;
  logic [OW:0]     rem;
  logic [OW+1:0]   end_b;
  logic            split;
  logic            legal;
  logic            sgn;
  logic            sbit;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] asm_word;
  logic [XLEN-1:0] ext_word;
  logic [XLEN-1:0] res_data;
  logic            res_err;

  assign in_ready      = !out_valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign split_pending = (state_q == HOLD_LO);

  // In HOLD_LO the captured mode governs; the second beat's mode is ignored.
  assign eff_mode = (state_q == HOLD_LO) ? mode_q : in_mode;

  // Field end position, used to detect a field running off the word's end.
  assign end_b = {2'b00, in_offset} + {1'b0, size_b};
  assign split = end_b > {1'b0, NB_W};

  // Assemble the field at bit 0: low bytes from the captured beat, the
  // remaining upper bytes from lane 0 upward of the second beat.
  always_comb begin
    rem      = NB_W - {1'b0, off_q};
    asm_word = '0;
    if (state_q == HOLD_LO) begin
      asm_word = lo_q | (in_data << {rem, 3'b000});
    end else begin
      asm_word = in_data >> {in_offset, 3'b000};
    end
  end

  // Decode access size, extension kind and legality from the effective mode.
  always_comb begin
    size_b = NB_W;
    mask   = '1;
    sgn    = 1'b0;
    sbit   = 1'b0;
    legal  = 1'b1;
    case (eff_mode)
      3'b000: begin
        size_b = NB_W;
      end
      3'b001, 3'b010: begin
        size_b = (OW+1)'(1);
        mask   = XLEN'(8'hFF);
        sgn    = (eff_mode == 3'b001);
        sbit   = asm_word[7];
      end
      3'b011, 3'b100: begin
        size_b = (OW+1)'(2);
        mask   = XLEN'(16'hFFFF);
        sgn    = (eff_mode == 3'b011);
        sbit   = asm_word[15];
      end
      3'b101, 3'b110: begin
        if (XLEN > 32) begin
          size_b = (OW+1)'(4);
          mask   = XLEN'(32'hFFFF_FFFF);
          sgn    = (eff_mode == 3'b101);
          sbit   = asm_word[31];
        end else begin
          legal  = 1'b0;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Sign-extend by filling above the field with ones, or zero-fill.
  assign ext_word = (sgn && sbit) ? (asm_word | ~mask) : (asm_word & mask);

  // Next-state and load/capture decisions.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    capture  = 1'b0;
    res_err  = 1'b0;
    res_data = ext_word;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            load     = 1'b1;
            res_err  = 1'b1;
            res_data = '0;
          end else if (split) begin
            if (MISALIGN_EN != 0) begin
              capture = 1'b1;
              state_d = HOLD_LO;
            end else begin
              load     = 1'b1;
              res_err  = 1'b1;
              res_data = '0;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      HOLD_LO: begin
        if (accept) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any half-captured split access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured lower part of a split access (already shifted down to lane 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= '0;
      mode_q <= '0;
      off_q  <= '0;
    end else if (capture) begin
      lo_q   <= asm_word;
      mode_q <= in_mode;
      off_q  <= in_offset;
    end
  end

  // Result register: load wins over retire so back-to-back results flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_err   <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// Testbench for load_ext_unit at XLEN=32: a split-capable instance checked by
// a scoreboard fed from a byte-level reference model, plus a MISALIGN_EN=0
// instance for the error path.
module tb_load_ext_unit;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready, out_err, split_pending;
  logic [2:0]      in_mode;
  logic [1:0]      in_offset;
  logic [XLEN-1:0] in_data, out_data;

  logic            n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_err, n_split_pending;
  logic [2:0]      n_in_mode;
  logic [1:0]      n_in_offset;
  logic [XLEN-1:0] n_in_data, n_out_data;

  load_ext_unit #(.XLEN(XLEN), .MISALIGN_EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_offset(in_offset), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .split_pending(split_pending)
  );

  load_ext_unit #(.XLEN(XLEN), .MISALIGN_EN(0)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_mode(n_in_mode),
    .in_offset(n_in_offset), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .out_err(n_out_err), .split_pending(n_split_pending)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [XLEN:0] exp_q[$];   // {err, data}

  logic        tb_pending = 1'b0;
  logic [2:0]  s_mode;
  int          s_off;
  logic [31:0] s_lo;
  logic        rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] m);
    case (m)
      3'd0:       return 4;
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      default:    return 0;   // illegal at XLEN=32
    endcase
  endfunction

  // Bytes off..off+S-1 of the little-endian pair {hi, lo}, as a number,
  // then sign or zero extended to 32 bits.
  function automatic logic [XLEN:0] ref_load(input logic [2:0] m, input int off,
                                             input logic [31:0] lo, input logic [31:0] hi);
    longint unsigned cat, val, lim;
    int s;
    s = size_of(m);
    if (s == 0) return {1'b1, 32'h0};
    cat = {hi, lo};
    lim = 64'd1 << (8 * s);
    val = (cat >> (8 * off)) % lim;
    if ((m == 3'd1 || m == 3'd3) && val >= lim / 2)
      val = val - lim + 64'h1_0000_0000;
    return {1'b0, val[31:0]};
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [2:0] m, input int off, input logic [31:0] d);
    int  n;
    bit  ok;
    in_mode = m; in_offset = 2'(off); in_data = d; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      chk("beat_accept_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    // Beat transfers at the coming edge: record what it should produce.
    if (tb_pending) begin
      exp_q.push_back(ref_load(s_mode, s_off, s_lo, d));
      tb_pending = 1'b0;
    end else if (size_of(m) == 0) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (off + size_of(m) > 4) begin
      tb_pending = 1'b1; s_mode = m; s_off = off; s_lo = d;
    end else begin
      exp_q.push_back(ref_load(m, off, d, 32'h0));
    end
    @(posedge clk); #1;
    chk("split_pending", 64'(split_pending), 64'(tb_pending));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic n_check(input logic [2:0] m, input int off, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_data);
    n_in_mode = m; n_in_offset = 2'(off); n_in_data = d; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    chk("noalign_valid", 64'(n_out_valid), 64'(1));
    chk("noalign_err", 64'(n_out_err), 64'(e_err));
    chk("noalign_data", 64'(n_out_data), 64'(e_data));
    chk("noalign_split_pending", 64'(n_split_pending), 64'(0));
  endtask

  // ---------------- random out_ready ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic          held;
    logic [XLEN:0] held_val;
    logic [XLEN:0] e;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid && held)
          chk("hold_stable", 64'({out_err, out_data}), 64'(held_val));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'({out_err, out_data}), 64'(e));
          end
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          held_val = {out_err, out_data};
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_offset = '0; in_data = '0;
    out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_mode = '0; n_in_offset = '0; n_in_data = '0;
    n_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_out_err", 64'(out_err), 64'(0));
    chk("reset_split_pending", 64'(split_pending), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_n_out_valid", 64'(n_out_valid), 64'(0));

    // Directed vectors.
    send_beat(3'b001, 3, 32'h80FF_FF00);
    chk("byte_signed_valid", 64'(out_valid), 64'(1));
    chk("byte_signed_data", 64'(out_data), 64'(32'hFFFF_FF80));
    chk("byte_signed_err", 64'(out_err), 64'(0));
    send_beat(3'b100, 2, 32'h8001_0000);
    chk("half_unsigned_data", 64'(out_data), 64'(32'h0000_8001));
    send_beat(3'b011, 2, 32'h8001_0000);
    chk("half_signed_data", 64'(out_data), 64'(32'hFFFF_8001));
    send_beat(3'b011, 1, 32'h00AB_CD00);
    chk("half_off1_data", 64'(out_data), 64'(32'hFFFF_ABCD));
    send_beat(3'b000, 1, 32'h4433_2211);
    chk("split_first_no_result", 64'(out_valid), 64'(0));
    send_beat(3'b011, 0, 32'h8877_6655);
    chk("split_full_data", 64'(out_data), 64'(32'h5544_3322));
    chk("split_full_err", 64'(out_err), 64'(0));
    send_beat(3'b111, 0, 32'h1234_5678);
    chk("illegal_111_err", 64'(out_err), 64'(1));
    chk("illegal_111_data", 64'(out_data), 64'(0));
    send_beat(3'b101, 0, 32'h1234_5678);
    chk("illegal_101_err", 64'(out_err), 64'(1));
    idle();
    idle();

    // Non-split instance: crossing access and illegal mode are errors.
    n_check(3'b000, 1, 32'h4433_2211, 1'b1, 32'h0);
    n_check(3'b111, 0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    n_check(3'b010, 1, 32'h0000_AB00, 1'b0, 32'h0000_00AB);
    n_check(3'b100, 3, 32'h1200_0000, 1'b1, 32'h0);

    // Stall: result held, in_ready low, data stable.
    out_ready = 1'b0;
    send_beat(3'b010, 0, 32'h0000_005A);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_data", 64'(out_data), 64'(32'h5A));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(3'b100, 0, 32'h1234_BEEF);
    chk("b2b_valid_1", 64'(out_valid), 64'(1));
    chk("b2b_data_1", 64'(out_data), 64'(32'h0000_BEEF));
    send_beat(3'b001, 0, 32'h0000_007F);
    chk("b2b_valid_2", 64'(out_valid), 64'(1));
    chk("b2b_data_2", 64'(out_data), 64'(32'h0000_007F));
    idle();
    drain();

    // Reset while the first half of a split is held.
    send_beat(3'b000, 2, 32'hDDCC_BBAA);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_pending = 1'b0;
    exp_q.delete();
    chk("rst_hold_split_pending", 64'(split_pending), 64'(0));
    chk("rst_hold_out_valid", 64'(out_valid), 64'(0));
    chk("rst_hold_in_ready", 64'(in_ready), 64'(1));
    send_beat(3'b010, 0, 32'h0000_00AB);
    chk("after_rst_data", 64'(out_data), 64'(32'h0000_00AB));
    chk("after_rst_err", 64'(out_err), 64'(0));
    idle();

    // Randomized traffic with random back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send_beat(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom);
    end
    in_valid = 1'b0;
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    if (tb_pending) send_beat(3'b000, 0, $urandom);
    idle();
    drain();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_ext_unit.md
LOAD_EXT_UNIT -- requirements
Module: load_ext_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width in bits; legal values 32, 64.
REQ-002 Parameter MISALIGN_EN, default 1, meaning 1 = accesses crossing a word boundary are assembled from two beats, 0 = such accesses are flagged as errors.
REQ-003 Derived: NB = XLEN/8 byte lanes; OW = log2(NB) offset width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  memory word beat present.
REQ-007 in_ready  output  1  unit accepts a beat this cycle.
REQ-008 in_mode  input  3  000 full XLEN, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned, 101 word signed, 110 word unsigned (101/110 legal only when XLEN=64), 111 illegal.
REQ-009 in_offset  input  OW  byte offset of the access within the word.
REQ-010 in_data  input  XLEN  memory read word.
REQ-011 out_valid  output  1  result register holds a result.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_data  output  XLEN  aligned and extended load result.
REQ-014 out_err  output  1  result is an error (illegal mode or disallowed split); qualified by out_valid.
REQ-015 split_pending  output  1  first beat of a split access captured; the next accepted beat is its upper word.

Function
REQ-016 Handshake: a beat transfers when in_valid && in_ready; a result retires when out_valid && out_ready.
REQ-017 in_ready SHALL be (!out_valid || out_ready) in every state, combinationally.
REQ-018 Access size S bytes: 1 (001/010), 2 (011/100), 4 (101/110), NB (000).
REQ-019 States: IDLE, HOLD_LO. Reset state IDLE.
REQ-020 IDLE, accepted beat, offset+S <= NB: extract bytes offset..offset+S-1, extend, load result register; out_valid=1 next cycle (latency 1); stay IDLE.
REQ-021 Misalignment within one word, e.g. half at offset 1, is legal and handled by REQ-020 without error.
REQ-022 IDLE, accepted beat, offset+S > NB, MISALIGN_EN=1: capture bytes offset..NB-1, latch mode and offset, go to HOLD_LO, split_pending=1, out_valid unaffected.
REQ-023 HOLD_LO, accepted beat: in_mode/in_offset ignored; low bytes from captured word, remaining S-(NB-offset) bytes from in_data lanes 0 upward; extend; load result register; return to IDLE; split_pending=0 next cycle; total latency 1 cycle after second beat.
REQ-024 offset+S > NB with MISALIGN_EN=0, or illegal mode (111; 101/110 at XLEN=32): result register loads out_err=1, out_data=0, latency 1, state IDLE.
REQ-025 Signed modes replicate the MSB of the extracted field to XLEN; unsigned modes zero-fill; mode 000 passes the assembled word unchanged.
REQ-026 Result register holds out_data/out_err stable while out_valid && !out_ready.
REQ-027 Retire and load in same cycle: new result replaces old, out_valid stays 1.
REQ-028 Retire with no new load: out_valid=0 next cycle; out_data holds last value.

Reset
REQ-029 rst=1 at an edge: state IDLE, out_valid=0, out_err=0, out_data=0, split_pending=0; any captured half of a split access is discarded.
REQ-030 rst takes priority over any simultaneous handshake; in_ready SHALL be 1 in the cycle after reset.

Verification
REQ-031 XLEN=32, mode 001, offset 3, in_data 0x80FFFF00 -> next cycle out_valid=1, out_data 0xFFFFFF80, out_err=0.
REQ-032 XLEN=32, mode 100, offset 2, in_data 0x80010000 -> out_data 0x00008001; mode 011 same data -> 0xFFFF8001.
REQ-033 XLEN=32, MISALIGN_EN=1, mode 000 offset 1 beat 0x44332211, then beat 0x88776655 -> split_pending=1 between beats, out_data 0x55443322 one cycle after second beat.
REQ-034 Same stimulus with MISALIGN_EN=0 -> after first beat out_err=1, out_data 0, split_pending stays 0; mode 111 -> out_err=1.
REQ-035 out_ready=0 with result held -> in_ready=0, out_data stable over 5 cycles; out_ready=1 with a new beat -> back-to-back results without a bubble.
REQ-036 rst asserted in HOLD_LO -> split_pending=0, out_valid=0; next aligned beat with mode 010 offset 0 data 0x000000AB -> out_data 0x000000AB.
